// File: rtl/pc_sequencer_if.sv
// Instruction-memory read port between the pc sequencer (master) and the memory (slave).
// The handshake is Avalon-style: address/read out, waitrequest back.
interface pc_sequencer_if;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;

    modport master (
        output instr_address,
        output instr_read,
        input  instr_waitrequest
    );

    modport slave (
        input  instr_address,
        input  instr_read,
        output instr_waitrequest
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-side program counter controller: issues instruction reads at pc, sequences MIPS
// branch delay slots and halts when pc reaches HALT_ADDR.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  stall,
    pc_sequencer_if.master        mem,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    output logic [31:0]           pc,
    output logic                  delay_slot,
    output logic                  fetch_accept,
    output logic [31:0]           fetch_count,
    output logic                  active,
    output logic                  err_branch_in_slot,
    output logic                  err_misaligned
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pending_target;
    logic [31:0] pc_plus4;
    logic        issue_read;

    // An open read in WAIT is never aborted; a new read is only issued from FETCH and
    // never to HALT_ADDR. Reset suppresses the request immediately.
    always_comb begin
        issue_read = 1'b0;
        if (!reset) begin
            if (state == WAIT) begin
                issue_read = 1'b1;
            end else if (state == FETCH && clk_enable && !stall && pc != HALT_ADDR) begin
                issue_read = 1'b1;
            end
        end
    end

    assign mem.instr_read    = issue_read;
    assign mem.instr_address = pc;
    assign fetch_accept      = issue_read & ~mem.instr_waitrequest;
    assign pc_plus4          = pc + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= FETCH;
            pc                 <= RESET_VECTOR;
            delay_slot         <= 1'b0;
            pending_target     <= 32'd0;
            fetch_count        <= 32'd0;
            active             <= 1'b1;
            err_branch_in_slot <= 1'b0;
            err_misaligned     <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (pc == HALT_ADDR && clk_enable) begin
                        state  <= HALT;
                        active <= 1'b0;
                    end else if (issue_read && mem.instr_waitrequest) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (!mem.instr_waitrequest) begin
                        state <= FETCH;
                    end
                end
                default: begin
                end
            endcase

            // A misaligned target overrides the state update above and stops the core.
            if (fetch_accept) begin
                fetch_count <= fetch_count + 32'd1;
                if (delay_slot) begin
                    pc         <= pending_target;
                    delay_slot <= 1'b0;
                    if (branch_taken) begin
                        err_branch_in_slot <= 1'b1;
                    end
                end else if (branch_taken && branch_target[1:0] != 2'b00) begin
                    err_misaligned <= 1'b1;
                    pc             <= pc_plus4;
                    state          <= HALT;
                    active         <= 1'b0;
                end else if (branch_taken) begin
                    pending_target <= branch_target;
                    delay_slot     <= 1'b1;
                    pc             <= pc_plus4;
                end else begin
                    pc <= pc_plus4;
                end
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic, all
// checked against a transaction-level model of the fetch stream.
module tb_pc_sequencer;

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] HALT = 32'h00000000;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] pc;
    logic        delay_slot;
    logic        fetch_accept;
    logic [31:0] fetch_count;
    logic        active;
    logic        err_branch_in_slot;
    logic        err_misaligned;

    pc_sequencer_if mem_if ();

    pc_sequencer #(
        .RESET_VECTOR(RV),
        .HALT_ADDR   (HALT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .clk_enable        (clk_enable),
        .stall             (stall),
        .mem               (mem_if),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .pc                (pc),
        .delay_slot        (delay_slot),
        .fetch_accept      (fetch_accept),
        .fetch_count       (fetch_count),
        .active            (active),
        .err_branch_in_slot(err_branch_in_slot),
        .err_misaligned    (err_misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a fetch stream with at most one outstanding read and a queue of
    // branch targets still waiting for their delay slot to be fetched.
    logic [31:0] m_pc;
    logic [31:0] m_count;
    logic [31:0] m_pending[$];
    bit          m_open;
    bit          m_halted;
    bit          m_err_slot;
    bit          m_err_mis;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_pc       = RV;
        m_count    = 32'd0;
        m_pending.delete();
        m_open     = 1'b0;
        m_halted   = 1'b0;
        m_err_slot = 1'b0;
        m_err_mis  = 1'b0;
    endtask

    // Drives one cycle of inputs, checks every output against the model, then advances it.
    task automatic applyStimulus(input bit r, input bit ce, input bit st, input bit wr,
                                 input bit bt, input logic [31:0] tgt);
        bit exp_read;
        bit exp_acc;
        @(negedge clk);
        reset                     = r;
        clk_enable                = ce;
        stall                     = st;
        mem_if.instr_waitrequest  = wr;
        branch_taken              = bt;
        branch_target             = tgt;
        #1;
        exp_read = !r && !m_halted && (m_open || (ce && !st && m_pc != HALT));
        exp_acc  = exp_read && !wr;
        checkOutput("instr_read", {31'd0, mem_if.instr_read}, {31'd0, exp_read});
        checkOutput("instr_address", mem_if.instr_address, m_pc);
        checkOutput("fetch_accept", {31'd0, fetch_accept}, {31'd0, exp_acc});
        checkOutput("pc", pc, m_pc);
        checkOutput("delay_slot", {31'd0, delay_slot}, {31'd0, m_pending.size() != 0});
        checkOutput("fetch_count", fetch_count, m_count);
        checkOutput("active", {31'd0, active}, {31'd0, !m_halted});
        checkOutput("err_branch_in_slot", {31'd0, err_branch_in_slot}, {31'd0, m_err_slot});
        checkOutput("err_misaligned", {31'd0, err_misaligned}, {31'd0, m_err_mis});

        if (r) begin
            modelReset();
        end else if (!m_halted) begin
            if (exp_acc) begin
                m_count = m_count + 32'd1;
                m_open  = 1'b0;
                if (m_pending.size() != 0) begin
                    m_pc = m_pending.pop_front();
                    if (bt) m_err_slot = 1'b1;
                end else if (bt && tgt[1:0] != 2'b00) begin
                    m_err_mis = 1'b1;
                    m_pc      = m_pc + 32'd4;
                    m_halted  = 1'b1;
                end else begin
                    if (bt) m_pending.push_back(tgt);
                    m_pc = m_pc + 32'd4;
                end
            end else if (exp_read) begin
                m_open = 1'b1;
            end else if (!m_open && ce && m_pc == HALT) begin
                m_halted = 1'b1;
            end
        end
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 32'd0);
    endtask

    initial begin
        int halted_cycles;
        bit r, ce, st, wr, bt;
        logic [31:0] tgt;
        logic [3:0]  kind;

        reset                    = 1'b1;
        clk_enable               = 1'b0;
        stall                    = 1'b0;
        mem_if.instr_waitrequest = 1'b0;
        branch_taken             = 1'b0;
        branch_target            = 32'd0;
        repeat (2) @(posedge clk);
        modelReset();

        // Zero-wait fetch after reset
        applyStimulus(1, 1, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("t1_read", {31'd0, mem_if.instr_read}, 32'd1);
        checkOutput("t1_addr", mem_if.instr_address, RV);
        idle();
        checkOutput("t1_pc", pc, 32'hBFC00004);
        checkOutput("t1_count", fetch_count, 32'd1);

        // Waitrequest held across a stall
        applyStimulus(1, 0, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 1, 0, 32'd0);
        applyStimulus(0, 1, 1, 1, 0, 32'd0);
        checkOutput("t2_read_held", {31'd0, mem_if.instr_read}, 32'd1);
        checkOutput("t2_pc_stable", pc, RV);
        applyStimulus(0, 0, 0, 1, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        idle();
        checkOutput("t2_pc", pc, 32'hBFC00004);

        // Taken branch through its delay slot
        applyStimulus(1, 0, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 1, 32'hBFC00100);
        applyStimulus(0, 0, 0, 0, 0, 32'd0);
        checkOutput("t3_slot_pc", pc, 32'hBFC00004);
        checkOutput("t3_slot_flag", {31'd0, delay_slot}, 32'd1);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        idle();
        checkOutput("t3_target_pc", pc, 32'hBFC00100);
        checkOutput("t3_slot_clear", {31'd0, delay_slot}, 32'd0);

        // Jump to the halt address
        applyStimulus(1, 0, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 1, 32'h00000000);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("t4_pc_zero", pc, 32'd0);
        checkOutput("t4_no_read", {31'd0, mem_if.instr_read}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 32'd0);
        checkOutput("t4_inactive", {31'd0, active}, 32'd0);
        checkOutput("t4_count", fetch_count, 32'd2);

        // Branch in a delay slot, then a misaligned target
        applyStimulus(1, 0, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 1, 32'hBFC00100);
        applyStimulus(0, 1, 0, 0, 1, 32'hBFC00200);
        applyStimulus(0, 1, 0, 0, 1, 32'hBFC00102);
        checkOutput("t5_err_slot", {31'd0, err_branch_in_slot}, 32'd1);
        checkOutput("t5_pc_target", pc, 32'hBFC00100);
        idle();
        checkOutput("t5_err_mis", {31'd0, err_misaligned}, 32'd1);
        checkOutput("t5_halted", {31'd0, active}, 32'd0);

        // Reset during WAIT with a pending branch
        applyStimulus(1, 0, 0, 0, 0, 32'd0);
        applyStimulus(0, 1, 0, 0, 1, 32'hBFC00100);
        applyStimulus(0, 1, 0, 1, 0, 32'd0);
        applyStimulus(1, 1, 0, 1, 0, 32'd0);
        checkOutput("t6_read_dropped", {31'd0, mem_if.instr_read}, 32'd0);
        idle();
        checkOutput("t6_pc", pc, RV);
        checkOutput("t6_slot", {31'd0, delay_slot}, 32'd0);
        checkOutput("t6_count", fetch_count, 32'd0);

        // Randomized traffic
        halted_cycles = 0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 59) == 0) || (halted_cycles > 4);
            ce = ($urandom_range(0, 99) < 85);
            st = ($urandom_range(0, 99) < 25);
            wr = ($urandom_range(0, 99) < 35);
            bt = ($urandom_range(0, 99) < 25);
            kind = 4'($urandom_range(0, 15));
            if (kind == 4'd0) begin
                tgt = HALT;
            end else if (kind == 4'd1) begin
                tgt = RV + 32'($urandom_range(0, 255) * 4) + 32'($urandom_range(1, 3));
            end else begin
                tgt = RV + 32'($urandom_range(0, 255) * 4);
            end
            applyStimulus(r, ce, st, wr, bt, tgt);
            halted_cycles = m_halted ? halted_cycles + 1 : 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
